// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts and a shift-add multiplier.
// Optional feature macro: ITERATIVE_ALU_MULT_EN enables the multiplier datapath. When it is
// not defined, MULT completes in one cycle with RESULT 0 and ERR set.
module iterative_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OpFwd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpSll = 3'b110;
    localparam logic [2:0] OpSra = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
`ifdef ITERATIVE_ALU_MULT_EN
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    logic             fin;
    logic [WIDTH-1:0] fin_val;
    logic             fin_err;
    logic [CW-1:0]    amt;
    logic [WIDTH-1:0] first_shift;

    function automatic logic [WIDTH-1:0] sll1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] sra1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    // Shift amount saturates at WIDTH; first_shift is the step performed on the accepting edge.
    always_comb begin
        amt         = (DATA2 >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(DATA2);
        first_shift = (SELECT == OpSra) ? sra1(DATA1) : sll1(DATA1);
    end

    // Next-state logic: accepts requests, iterates in StBusy, commits results on completion.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        a_d      = a_q;
`ifdef ITERATIVE_ALU_MULT_EN
        b_d      = b_q;
        acc_d    = acc_q;
`endif
        fin      = 1'b0;
        fin_val  = '0;
        fin_err  = 1'b0;

        unique case (state_q)
            StBusy: begin
                // Inputs are ignored here; only the latched operands advance.
`ifdef ITERATIVE_ALU_MULT_EN
                if (sel_q == OpMul) begin
                    acc_d   = acc_q + (b_q[0] ? a_q : '0);
                    a_d     = sll1(a_q);
                    b_d     = b_q >> 1;
                    fin_val = acc_d;
                end else
`endif
                if (sel_q == OpSra) begin
                    a_d     = sra1(a_q);
                    fin_val = a_d;
                end else begin
                    a_d     = sll1(a_q);
                    fin_val = a_d;
                end
                cnt_d = cnt_q - CW'(1);
                fin   = (cnt_q == CW'(1));
            end
            default: begin
                state_d = StIdle;
                if (START) begin
                    sel_d = SELECT;
                    case (SELECT)
                        OpFwd: begin fin = 1'b1; fin_val = DATA2;         end
                        OpAdd: begin fin = 1'b1; fin_val = DATA1 + DATA2; end
                        OpAnd: begin fin = 1'b1; fin_val = DATA1 & DATA2; end
                        OpOr:  begin fin = 1'b1; fin_val = DATA1 | DATA2; end
                        OpSub: begin fin = 1'b1; fin_val = DATA1 - DATA2; end
                        OpMul: begin
`ifdef ITERATIVE_ALU_MULT_EN
                            // First shift-add step happens on the accepting edge.
                            acc_d   = DATA2[0] ? DATA1 : '0;
                            a_d     = sll1(DATA1);
                            b_d     = DATA2 >> 1;
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = StBusy;
`else
                            fin     = 1'b1;
                            fin_val = '0;
                            fin_err = 1'b1;
`endif
                        end
                        default: begin
                            if (amt == '0) begin
                                fin     = 1'b1;
                                fin_val = DATA1;
                            end else if (amt == CW'(1)) begin
                                fin     = 1'b1;
                                fin_val = first_shift;
                            end else begin
                                a_d     = first_shift;
                                cnt_d   = amt - CW'(1);
                                state_d = StBusy;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (fin) begin
            state_d  = StDone;
            result_d = fin_val;
            zero_d   = (fin_val == '0);
            err_d    = fin_err;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= '0;
            a_q      <= '0;
`ifdef ITERATIVE_ALU_MULT_EN
            b_q      <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
`ifdef ITERATIVE_ALU_MULT_EN
            b_q      <= b_d;
            acc_q    <= acc_d;
`endif
        end
    end

    // Output decode.
    always_comb begin
        RESULT = result_q;
        ZERO   = zero_q;
        ERR    = err_q;
        BUSY   = (state_q == StBusy);
        DONE   = (state_q == StDone);
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu (WIDTH=8): vector table plus hand-written multi-cycle sequences.
module tb_iterative_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sel;
    logic [7:0] d1, d2;
    logic [7:0] result;
    logic       zero, busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    iterative_alu #(.WIDTH(8)) dut (
        .CLK(clk), .RESET(rst), .START(start), .SELECT(sel), .DATA1(d1), .DATA2(d2),
        .RESULT(result), .ZERO(zero), .BUSY(busy), .DONE(done), .ERR(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zero;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs while waiting, return latency and BUSY cycles seen.
    task automatic do_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; sel = s; d1 = a; d2 = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            sel = 3'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc;

        vecs[0]  = '{3'b001, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'b100, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b000, 8'h3C, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b011, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1};
        vecs[5]  = '{3'b111, 8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 3};
        vecs[6]  = '{3'b110, 8'h81, 8'h09, 8'h00, 1'b1, 1'b0, 8};
        vecs[7]  = '{3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b111, 8'h80, 8'hC8, 8'hFF, 1'b0, 1'b0, 8};
        vecs[9]  = '{3'b110, 8'h03, 8'h01, 8'h06, 1'b0, 1'b0, 1};
        vecs[10] = '{3'b111, 8'h7F, 8'h02, 8'h1F, 1'b0, 1'b0, 2};
`ifdef ITERATIVE_ALU_MULT_EN
        vecs[11] = '{3'b101, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 8};
        vecs[12] = '{3'b100, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b101, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 8};
`else
        vecs[11] = '{3'b101, 8'd13, 8'd11, 8'h00, 1'b1, 1'b1, 1};
        vecs[12] = '{3'b100, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b101, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1};
`endif
        vecs[14] = '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1};

        rst = 1'b1; start = 1'b0; sel = '0; d1 = '0; d2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", 32'(result), 32'h00);
        chk("reset_zero", 32'(zero), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
        end

        // Back-to-back: SUB to zero, then FORWARD accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; sel = 3'b100; d1 = 8'h05; d2 = 8'h05;
        @(negedge clk);
        chk("b2b_done1", 32'(done), 32'h1);
        chk("b2b_result1", 32'(result), 32'h00);
        chk("b2b_zero1", 32'(zero), 32'h1);
        sel = 3'b000; d2 = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", 32'(done), 32'h1);
        chk("b2b_result2", 32'(result), 32'hA5);
        chk("b2b_zero2", 32'(zero), 32'h0);
        @(negedge clk);
        chk("b2b_idle", 32'(done), 32'h0);

        // START pulsed mid-BUSY must be ignored: SLL 01 by 7 -> 80 in 7 cycles.
        @(negedge clk);
        start = 1'b1; sel = 3'b110; d1 = 8'h01; d2 = 8'h07;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = 3'b001; d1 = 8'h11; d2 = 8'h22;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_latency", 32'(lat), 32'd7);
        chk("ignore_result", 32'(result), 32'h80);
        @(negedge clk);
        chk("ignore_no_extra_done", 32'(done), 32'h0);

        // Reset on the 4th BUSY cycle of an 8-cycle operation aborts with no DONE.
        @(negedge clk);
        start = 1'b1;
`ifdef ITERATIVE_ALU_MULT_EN
        sel = 3'b101; d1 = 8'd13; d2 = 8'd11;
`else
        sel = 3'b111; d1 = 8'h80; d2 = 8'h08;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_result", 32'(result), 32'h00);
        chk("abort_zero", 32'(zero), 32'h1);
        rst = 1'b0;
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) bc++;
        end
        chk("abort_no_done", 32'(bc), 32'd0);

        // ADD accepted on the first edge after reset deasserts.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b1; sel = 3'b001; d1 = 8'h01; d2 = 8'h02;
        @(negedge clk);
        start = 1'b0;
        chk("post_reset_done", 32'(done), 32'h1);
        chk("post_reset_result", 32'(result), 32'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
